// File: rtl/apb_master_arb.sv
// APB master shared by two requesters: round-robin grant, address-decoded slave select,
// IDLE->SETUP->ACCESS sequencing, decode-error completion and a wait-state timeout.
module apb_master_arb #(
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 10,
    parameter int TIMEOUT = 16
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_write,
    input  logic [63:0]            req_addr,
    input  logic [63:0]            req_wdata,
    output logic [1:0]             req_ack,
    output logic [1:0]             rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [NUM_SLV-1:0]     psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [31:0]            paddr,
    output logic [31:0]            pwdata,
    input  logic [NUM_SLV*32-1:0]  prdata,
    input  logic [NUM_SLV-1:0]     pready,
    input  logic [NUM_SLV-1:0]     pslverr
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
    localparam logic [3:0]       NUM_SLV_L = 4'(NUM_SLV);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_SLV-1:0] psel_d;
    logic               penable_d;
    logic               pwrite_d;
    logic [31:0]        paddr_d;
    logic [31:0]        pwdata_d;
    logic [1:0]         req_ack_d;
    logic [1:0]         rsp_valid_d;
    logic [31:0]        rsp_rdata_d;
    logic               rsp_err_d;

    logic               grant;
    logic               gnt_write;
    logic [31:0]        gnt_addr;
    logic [31:0]        gnt_wdata;
    logic [2:0]         gnt_idx;

    logic               sel_ready;
    logic               sel_err;
    logic [31:0]        sel_rdata;

    function automatic logic [NUM_SLV-1:0] decode_sel(input logic [2:0] idx);
        logic [NUM_SLV-1:0] onehot;
        onehot = '0;
        for (int s = 0; s < NUM_SLV; s++) begin
            onehot[s] = (idx == 3'(s));
        end
        return onehot;
    endfunction

    // Pointer holds the last granted requester; on contention the other one wins.
    always_comb begin
        grant     = (req_valid == 2'b11) ? ~ptr_q : req_valid[1];
        gnt_write = grant ? req_write[1]      : req_write[0];
        gnt_addr  = grant ? req_addr[63:32]   : req_addr[31:0];
        gnt_wdata = grant ? req_wdata[63:32]  : req_wdata[31:0];
        gnt_idx   = gnt_addr[SEL_LSB +: 3];
    end

    // The registered one-hot psel doubles as the response mux select.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int s = 0; s < NUM_SLV; s++) begin
            if (psel[s]) begin
                sel_ready = pready[s];
                sel_err   = pslverr[s];
                sel_rdata = prdata[32*s +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        psel_d      = psel;
        penable_d   = penable;
        pwrite_d    = pwrite;
        paddr_d     = paddr;
        pwdata_d    = pwdata;
        req_ack_d   = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                psel_d    = '0;
                penable_d = 1'b0;
                if (|req_valid) begin
                    ptr_d            = grant;
                    owner_d          = grant;
                    pwrite_d         = gnt_write;
                    paddr_d          = gnt_addr;
                    pwdata_d         = gnt_wdata;
                    req_ack_d[grant] = 1'b1;
                    if ({1'b0, gnt_idx} < NUM_SLV_L) begin
                        state_d = SETUP;
                        psel_d  = decode_sel(gnt_idx);
                    end else begin
                        state_d = DERR;
                    end
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = CNT_W'(1);
            end

            ACCESS: begin
                // A ready slave on the final allowed cycle still completes normally.
                if (sel_ready || (cnt_q == CNT_MAX)) begin
                    state_d              = IDLE;
                    psel_d               = '0;
                    penable_d            = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = sel_ready ? sel_err : 1'b1;
                    rsp_rdata_d          = (sel_ready && !sel_err && !pwrite) ? sel_rdata : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DERR: begin
                state_d              = IDLE;
                rsp_valid_d[owner_q] = 1'b1;
                rsp_err_d            = 1'b1;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            req_ack   <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            psel      <= psel_d;
            penable   <= penable_d;
            pwrite    <= pwrite_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
            req_ack   <= req_ack_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule
